// File: rtl/milano_pkg.sv
// milano_pkg: shared types and helpers for the milano load/store unit.
//   lsu_opt_e   - memory access type presented by ID/EX
//   lsu_state_e - LSU bus FSM states
//   lsu_aligned / lsu_be / lsu_wdata - per-access alignment, byte-enable
//   and store-lane helpers used when an access is accepted.
package milano_pkg;

   typedef enum logic [3:0] {
      LSU_NONE,
      LSU_LB,
      LSU_LH,
      LSU_LW,
      LSU_LBU,
      LSU_LHU,
      LSU_SB,
      LSU_SH,
      LSU_SW
   } lsu_opt_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID
   } lsu_state_e;

   // Halfwords need an even address, words a 4-byte aligned address.
   function automatic logic lsu_aligned(input lsu_opt_e op, input logic [1:0] off);
      logic ok;
      case (op)
         LSU_LH, LSU_LHU, LSU_SH: ok = ~off[0];
         LSU_LW, LSU_SW:          ok = (off == 2'b00);
         default:                 ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lsu_be(input lsu_opt_e op, input logic [1:0] off);
      logic [3:0] be;
      case (op)
         LSU_LB, LSU_LBU, LSU_SB: be = 4'b0001 << off;
         LSU_LH, LSU_LHU, LSU_SH: be = 4'b0011 << off;
         LSU_LW, LSU_SW:          be = 4'b1111;
         default:                 be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicating the datum across all lanes means the byte enables alone
   // select the target lane; no shifter is needed on the store path.
   function automatic logic [31:0] lsu_wdata(input lsu_opt_e op, input logic [31:0] wdata);
      logic [31:0] d;
      case (op)
         LSU_SB:  d = {4{wdata[7:0]}};
         LSU_SH:  d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load lane extraction and extension.
//   rdata_i [31:0] - raw word from the data memory
//   op_i           - load type (store/none types yield the raw word)
//   off_i   [1:0]  - byte offset within the word
//   data_o  [31:0] - aligned, sign- or zero-extended load result
module lsu_load_align
   import milano_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  lsu_opt_e    op_i,
   input  logic [1:0]  off_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata_i >> {off_i, 3'b000};
      case (op_i)
         LSU_LB:  data_o = {{24{shifted[7]}}, shifted[7:0]};
         LSU_LBU: data_o = {24'h0, shifted[7:0]};
         LSU_LH:  data_o = {{16{shifted[15]}}, shifted[15:0]};
         LSU_LHU: data_o = {16'h0, shifted[15:0]};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit for the milano core.
//   EX side : lsu_req_ex_i, lsu_we_ex_i, lsu_operate_ex_i, lsu_addr_ex_i,
//             lsu_wdata_ex_i in; lsu_rdata_o, lsu_rvalid_o, lsu_busy_o,
//             lsu_misaligned_o out.
//   Mem side: data_req_o/data_gnt_i request handshake, data_addr_o,
//             data_we_o, data_be_o, data_wdata_o, data_rvalid_i,
//             data_rdata_i.
//
// Handshake: data_req_o is held high with stable addr/we/be/wdata until
// data_gnt_i is seen; exactly one data_rvalid_i then closes the access.
// Only one access is outstanding, so gnt outside WAIT_GNT and rvalid
// outside WAIT_RVALID carry no meaning and are ignored.
module lsu_ctrl
   import milano_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_req_ex_i,
   input  logic        lsu_we_ex_i,
   input  lsu_opt_e    lsu_operate_ex_i,
   input  logic [31:0] lsu_addr_ex_i,
   input  logic [31:0] lsu_wdata_ex_i,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_rvalid_o,
   output logic        lsu_busy_o,
   output logic        lsu_misaligned_o
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   lsu_opt_e    op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        misaligned_q, misaligned_d;

   logic        new_access;
   logic        aligned;
   logic [31:0] load_data;

   lsu_load_align u_load_align (
      .rdata_i (data_rdata_i),
      .op_i    (op_q),
      .off_i   (addr_q[1:0]),
      .data_o  (load_data)
   );

   assign new_access = lsu_req_ex_i && (lsu_operate_ex_i != LSU_NONE);
   assign aligned    = lsu_aligned(lsu_operate_ex_i, lsu_addr_ex_i[1:0]);

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      op_d         = op_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      rvalid_d     = 1'b0;
      misaligned_d = 1'b0;
      lsu_busy_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (new_access) begin
               if (aligned) begin
                  // Busy is raised combinationally so EX holds this
                  // instruction in the same cycle it is accepted.
                  lsu_busy_o = 1'b1;
                  we_d       = lsu_we_ex_i;
                  op_d       = lsu_operate_ex_i;
                  addr_d     = lsu_addr_ex_i;
                  be_d       = lsu_be(lsu_operate_ex_i, lsu_addr_ex_i[1:0]);
                  wdata_d    = lsu_wdata(lsu_operate_ex_i, lsu_wdata_ex_i);
                  state_d    = WAIT_GNT;
               end else begin
                  misaligned_d = 1'b1;
               end
            end
         end
         WAIT_GNT: begin
            lsu_busy_o = 1'b1;
            if (data_gnt_i) state_d = WAIT_RVALID;
         end
         WAIT_RVALID: begin
            lsu_busy_o = 1'b1;
            if (data_rvalid_i) begin
               if (!we_q) begin
                  rdata_d  = load_data;
                  rvalid_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         op_q         <= LSU_NONE;
         addr_q       <= 32'h0;
         be_q         <= 4'h0;
         wdata_q      <= 32'h0;
         rdata_q      <= 32'h0;
         rvalid_q     <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign data_req_o       = (state_q == WAIT_GNT);
   assign data_addr_o      = {addr_q[31:2], 2'b00};
   assign data_we_o        = we_q;
   assign data_be_o        = be_q;
   assign data_wdata_o     = wdata_q;
   assign lsu_rdata_o      = rdata_q;
   assign lsu_rvalid_o     = rvalid_q;
   assign lsu_misaligned_o = misaligned_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. Expected load results are
// queued when a load's response is driven and compared when lsu_rvalid_o
// fires; bus fields, busy and pulses are checked cycle by cycle.
module tb_lsu_ctrl;
   import milano_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        lsu_req_ex_i = 1'b0;
   logic        lsu_we_ex_i = 1'b0;
   lsu_opt_e    lsu_operate_ex_i = LSU_NONE;
   logic [31:0] lsu_addr_ex_i = 32'h0;
   logic [31:0] lsu_wdata_ex_i = 32'h0;
   logic        data_req_o;
   logic        data_gnt_i = 1'b0;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i = 1'b0;
   logic [31:0] data_rdata_i = 32'h0;
   logic [31:0] lsu_rdata_o;
   logic        lsu_rvalid_o;
   logic        lsu_busy_o;
   logic        lsu_misaligned_o;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   lsu_ctrl dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .lsu_req_ex_i     (lsu_req_ex_i),
      .lsu_we_ex_i      (lsu_we_ex_i),
      .lsu_operate_ex_i (lsu_operate_ex_i),
      .lsu_addr_ex_i    (lsu_addr_ex_i),
      .lsu_wdata_ex_i   (lsu_wdata_ex_i),
      .data_req_o       (data_req_o),
      .data_gnt_i       (data_gnt_i),
      .data_addr_o      (data_addr_o),
      .data_we_o        (data_we_o),
      .data_be_o        (data_be_o),
      .data_wdata_o     (data_wdata_o),
      .data_rvalid_i    (data_rvalid_i),
      .data_rdata_i     (data_rdata_i),
      .lsu_rdata_o      (lsu_rdata_o),
      .lsu_rvalid_o     (lsu_rvalid_o),
      .lsu_busy_o       (lsu_busy_o),
      .lsu_misaligned_o (lsu_misaligned_o)
   );

   // clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: no end of test, got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model
   function automatic logic is_store(input lsu_opt_e op);
      return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
   endfunction

   function automatic logic [3:0] model_be(input lsu_opt_e op, input logic [1:0] off);
      case (op)
         LSU_LB, LSU_LBU, LSU_SB:
            case (off)
               2'd0: return 4'b0001;
               2'd1: return 4'b0010;
               2'd2: return 4'b0100;
               default: return 4'b1000;
            endcase
         LSU_LH, LSU_LHU, LSU_SH: return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input lsu_opt_e op, input logic [31:0] w);
      case (op)
         LSU_SB:  return {w[7:0], w[7:0], w[7:0], w[7:0]};
         LSU_SH:  return {w[15:0], w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input lsu_opt_e op, input logic [1:0] off,
                                              input logic [31:0] r);
      logic [7:0]  b;
      logic [15:0] h;
      b = r[off*8 +: 8];
      h = off[1] ? r[31:16] : r[15:0];
      case (op)
         LSU_LB:  return {{24{b[7]}}, b};
         LSU_LBU: return {24'h0, b};
         LSU_LH:  return {{16{h[15]}}, h};
         LSU_LHU: return {16'h0, h};
         default: return r;
      endcase
   endfunction

   // scoreboard: every load result must match the oldest queued expectation
   always @(negedge clk_i) begin
      if (rst_ni && lsu_rvalid_o) begin
         if (exp_q.size() == 0) check_eq("unexpected_rvalid", 32'd1, 32'd0);
         else check_eq("load_data", lsu_rdata_o, exp_q.pop_front());
      end
      if (lsu_misaligned_o) check_eq("misaligned_vs_req", {31'h0, data_req_o}, 32'd0);
   end

   // driver: called before the posedge of the accept cycle (c0); returns
   // at the negedge of the cycle after rvalid (c3).
   task automatic do_access(input lsu_opt_e op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int gnt_wait);
      logic st;
      st = is_store(op);
      lsu_req_ex_i     = 1'b1;
      lsu_we_ex_i      = st;
      lsu_operate_ex_i = op;
      lsu_addr_ex_i    = addr;
      lsu_wdata_ex_i   = wdata;
      #1;
      check_eq("busy_c0", {31'h0, lsu_busy_o}, 32'd1);
      check_eq("req_c0", {31'h0, data_req_o}, 32'd0);
      @(posedge clk_i); #1;
      lsu_req_ex_i     = 1'b0;
      lsu_operate_ex_i = LSU_NONE;
      lsu_addr_ex_i    = $urandom;
      lsu_wdata_ex_i   = $urandom;
      for (int i = 0; i <= gnt_wait; i++) begin
         data_gnt_i    = (i == gnt_wait);
         // stray responses before the grant must be ignored
         data_rvalid_i = (i != gnt_wait) && ($urandom_range(0, 1) == 1);
         @(negedge clk_i);
         check_eq("req_held", {31'h0, data_req_o}, 32'd1);
         check_eq("addr", data_addr_o, {addr[31:2], 2'b00});
         check_eq("we", {31'h0, data_we_o}, {31'h0, st});
         check_eq("be", {28'h0, data_be_o}, {28'h0, model_be(op, addr[1:0])});
         if (st) check_eq("wdata", data_wdata_o, model_wdata(op, wdata));
         check_eq("busy_gnt", {31'h0, lsu_busy_o}, 32'd1);
         @(posedge clk_i); #1;
      end
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = rdata;
      if (!st) exp_q.push_back(model_load(op, addr[1:0], rdata));
      @(negedge clk_i);
      check_eq("req_after_gnt", {31'h0, data_req_o}, 32'd0);
      check_eq("busy_rvalid", {31'h0, lsu_busy_o}, 32'd1);
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b0;
      data_rdata_i  = $urandom;
      @(negedge clk_i);
      check_eq("busy_c3", {31'h0, lsu_busy_o}, 32'd0);
      check_eq("rvalid_pulse", {31'h0, lsu_rvalid_o}, {31'h0, ~st});
   endtask

   task automatic do_reject(input lsu_opt_e op, input logic [31:0] addr, input logic exp_mis);
      lsu_req_ex_i     = 1'b1;
      lsu_we_ex_i      = is_store(op);
      lsu_operate_ex_i = op;
      lsu_addr_ex_i    = addr;
      #1;
      check_eq("reject_busy", {31'h0, lsu_busy_o}, 32'd0);
      @(posedge clk_i); #1;
      lsu_req_ex_i     = 1'b0;
      lsu_operate_ex_i = LSU_NONE;
      @(negedge clk_i);
      check_eq("reject_req", {31'h0, data_req_o}, 32'd0);
      check_eq("reject_mis", {31'h0, lsu_misaligned_o}, {31'h0, exp_mis});
      @(negedge clk_i);
      check_eq("reject_mis_once", {31'h0, lsu_misaligned_o}, 32'd0);
      check_eq("reject_req2", {31'h0, data_req_o}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"}, {31'h0, data_req_o}, 32'd0);
      check_eq({tag, "_we"}, {31'h0, data_we_o}, 32'd0);
      check_eq({tag, "_be"}, {28'h0, data_be_o}, 32'd0);
      check_eq({tag, "_addr"}, data_addr_o, 32'd0);
      check_eq({tag, "_wdata"}, data_wdata_o, 32'd0);
      check_eq({tag, "_rdata"}, lsu_rdata_o, 32'd0);
      check_eq({tag, "_rvalid"}, {31'h0, lsu_rvalid_o}, 32'd0);
      check_eq({tag, "_mis"}, {31'h0, lsu_misaligned_o}, 32'd0);
      check_eq({tag, "_busy"}, {31'h0, lsu_busy_o}, 32'd0);
   endtask

   lsu_opt_e ops[8] = '{LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW};

   initial begin
      // reset
      repeat (2) @(negedge clk_i);
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);

      // directed cases
      do_access(LSU_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      do_access(LSU_LB, 32'h103, 32'h0, 32'h80FF0000, 0);
      do_access(LSU_LBU, 32'h103, 32'h0, 32'h80FF0000, 1);
      do_access(LSU_SH, 32'h202, 32'h1234ABCD, 32'h0, 3);
      do_reject(LSU_LW, 32'h101, 1'b1);
      do_reject(LSU_SH, 32'h303, 1'b1);
      do_reject(LSU_NONE, 32'h104, 1'b0);
      // back-to-back: second request presented in the cycle the FSM is idle again
      do_access(LSU_SW, 32'h400, 32'hCAFEF00D, 32'h0, 0);
      do_access(LSU_LH, 32'h402, 32'h0, 32'h9ABC1234, 0);
      do_access(LSU_LHU, 32'h402, 32'h0, 32'h9ABC1234, 2);

      // randomized aligned accesses
      for (int n = 0; n < 24; n++) begin
         lsu_opt_e op;
         logic [31:0] a;
         op = ops[$urandom_range(0, 7)];
         a = $urandom & 32'hFFFF_FFFC;
         case (op)
            LSU_LB, LSU_LBU, LSU_SB: a[1:0] = 2'($urandom_range(0, 3));
            LSU_LH, LSU_LHU, LSU_SH: a[1] = 1'($urandom_range(0, 1));
            default: ;
         endcase
         do_access(op, a, $urandom, $urandom, $urandom_range(0, 3));
      end

      // reset while waiting for the response
      @(negedge clk_i);
      lsu_req_ex_i     = 1'b1;
      lsu_we_ex_i      = 1'b0;
      lsu_operate_ex_i = LSU_LW;
      lsu_addr_ex_i    = 32'h500;
      @(posedge clk_i); #1;
      lsu_req_ex_i     = 1'b0;
      lsu_operate_ex_i = LSU_NONE;
      data_gnt_i       = 1'b1;
      @(posedge clk_i); #1;
      data_gnt_i = 1'b0;
      rst_ni     = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h11223344;
      @(negedge clk_i);
      check_eq("late_rvalid_busy", {31'h0, lsu_busy_o}, 32'd0);
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b0;
      @(negedge clk_i);
      check_eq("late_rvalid_pulse", {31'h0, lsu_rvalid_o}, 32'd0);
      check_eq("late_rvalid_req", {31'h0, data_req_o}, 32'd0);

      // after reset the unit works again
      do_access(LSU_LB, 32'h601, 32'h0, 32'h00007F00, 0);

      repeat (2) @(negedge clk_i);
      check_eq("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
